// File: rtl/neureka_weight_bitserializer.sv
// Bit-plane serializer for neureka binconv weights: one packed word in,
// qw LSB-first bit-planes out, with bit index and last-plane flag.

module neureka_wbs_lane #(
   parameter int unsigned QW    = 8,
   parameter int unsigned CNT_W = $clog2(QW)
) (
   input  logic [QW-1:0]    row_i,
   input  logic [CNT_W-1:0] sel_i,
   input  logic             en_i,
   output logic             bit_o
);
   assign bit_o = en_i & row_i[sel_i];
endmodule

module neureka_weight_bitserializer #(
   parameter int unsigned COLUMN_SIZE = 9,
   parameter int unsigned QW          = 8,
   parameter int unsigned CNT_W       = $clog2(QW)
) (
   input  logic                      clk_gated,
   input  logic                      rst_ni,
   input  logic                      enable_i,
   input  logic                      clear_i,
   input  logic [CNT_W:0]            qw_i,
   input  logic [COLUMN_SIZE-1:0]    row_mask_i,
   input  logic                      wword_valid_i,
   output logic                      wword_ready_o,
   input  logic [COLUMN_SIZE*QW-1:0] wword_data_i,
   output logic                      wbit_valid_o,
   input  logic                      wbit_ready_i,
   output logic [COLUMN_SIZE-1:0]    wbit_data_o,
   output logic [CNT_W-1:0]          block_cnt_o,
   output logic                      last_o
);

   typedef enum logic {IDLE, SERIAL} state_e;

   state_e                    state_q, state_d;
   logic [COLUMN_SIZE*QW-1:0] word_q, word_d;
   logic [CNT_W:0]            qw_q, qw_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [COLUMN_SIZE-1:0]    mask_q, mask_d;

   logic           en, serial, last, out_hs, in_hs;
   logic [CNT_W:0] qw_sat;

   assign en     = enable_i & ~clear_i;
   assign serial = (state_q == SERIAL);
   assign last   = serial & ({1'b0, cnt_q} == qw_q - (CNT_W+1)'(1));
   assign out_hs = en & serial & wbit_ready_i;

   // Reload is allowed in the same cycle the last plane is consumed, so
   // back-to-back words stream without a bubble.
   assign wword_ready_o = en & (~serial | (last & wbit_ready_i));
   assign in_hs         = wword_ready_o & wword_valid_i;

   always_comb begin
      qw_sat = qw_i;
      if (qw_i == '0)                    qw_sat = (CNT_W+1)'(1);
      else if (qw_i > (CNT_W+1)'(QW))    qw_sat = (CNT_W+1)'(QW);
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      qw_d    = qw_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      if (clear_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (en) begin
         if (in_hs) begin
            word_d  = wword_data_i;
            mask_d  = row_mask_i;
            qw_d    = qw_sat;
            cnt_d   = '0;
            state_d = SERIAL;
         end else if (out_hs) begin
            if (last) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_gated or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         word_q  <= '0;
         qw_q    <= (CNT_W+1)'(1);
         cnt_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         qw_q    <= qw_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
      end
   end

   genvar r;
   generate
      for (r = 0; r < COLUMN_SIZE; r++) begin : g_lane
         neureka_wbs_lane #(.QW(QW), .CNT_W(CNT_W)) u_lane (
            .row_i (word_q[r*QW +: QW]),
            .sel_i (cnt_q),
            .en_i  (serial & mask_q[r]),
            .bit_o (wbit_data_o[r])
         );
      end
   endgenerate

   assign wbit_valid_o = serial;
   assign block_cnt_o  = cnt_q;
   assign last_o       = last;

endmodule

// File: tb/tb_neureka_weight_bitserializer.sv
// Scoreboard bench: each accepted word expands into its expected bit-planes,
// a negedge monitor compares every presented plane and the ready/valid rules.

module tb_neureka_weight_bitserializer;
   localparam int CS = 9;
   localparam int QW = 8;
   localparam int CW = 3;

   logic clk_gated = 1'b0;
   logic rst_ni;
   logic enable_i, clear_i;
   logic [CW:0] qw_i;
   logic [CS-1:0] row_mask_i;
   logic wword_valid_i, wword_ready_o;
   logic [CS*QW-1:0] wword_data_i;
   logic wbit_valid_o, wbit_ready_i;
   logic [CS-1:0] wbit_data_o;
   logic [CW-1:0] block_cnt_o;
   logic last_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct { logic [CS-1:0] d; int c; logic l; } plane_t;
   plane_t sbq[$];

   neureka_weight_bitserializer #(.COLUMN_SIZE(CS), .QW(QW)) dut (
      .clk_gated(clk_gated), .rst_ni(rst_ni), .enable_i(enable_i), .clear_i(clear_i),
      .qw_i(qw_i), .row_mask_i(row_mask_i), .wword_valid_i(wword_valid_i),
      .wword_ready_o(wword_ready_o), .wword_data_i(wword_data_i),
      .wbit_valid_o(wbit_valid_o), .wbit_ready_i(wbit_ready_i),
      .wbit_data_o(wbit_data_o), .block_cnt_o(block_cnt_o), .last_o(last_o)
   );

   always #5 clk_gated = ~clk_gated;
   always @(posedge clk_gated) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
   endtask

   // Monitor + reference model
   always @(negedge clk_gated) begin
      logic en, hs, exp_rdy;
      int qe;
      plane_t p;
      if (!rst_ni) begin
         sbq.delete();
      end else begin
         en = enable_i && !clear_i;
         chk("valid", wbit_valid_o, sbq.size() != 0);
         exp_rdy = en && (sbq.size() == 0 || (sbq[0].l && wbit_ready_i));
         chk("wword_ready", wword_ready_o, exp_rdy);
         if (wbit_valid_o && sbq.size() != 0) begin
            chk("data", wbit_data_o, sbq[0].d);
            chk("block_cnt", block_cnt_o, sbq[0].c);
            chk("last", last_o, sbq[0].l);
         end
         hs = en && wbit_valid_o && wbit_ready_i;
         if (clear_i) sbq.delete();
         else if (hs && sbq.size() != 0) void'(sbq.pop_front());
         if (en && wword_valid_i && wword_ready_o) begin
            qe = (qw_i == 0) ? 1 : ((qw_i > QW) ? QW : int'(qw_i));
            for (int b = 0; b < qe; b++) begin
               for (int r = 0; r < CS; r++)
                  p.d[r] = wword_data_i[r*QW + b] & row_mask_i[r];
               p.c = b;
               p.l = (b == qe - 1);
               sbq.push_back(p);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_gated);
      #1;
   endtask

   task automatic send(input logic [CS*QW-1:0] d, input logic [CW:0] q, input logic [CS-1:0] m);
      logic acc;
      int n = 0;
      wword_valid_i = 1'b1;
      wword_data_i  = d;
      qw_i          = q;
      row_mask_i    = m;
      acc = 1'b0;
      while (!acc && n < 60) begin
         @(negedge clk_gated);
         acc = wword_ready_o && enable_i && !clear_i;
         tick();
         n++;
      end
      wword_valid_i = 1'b0;
      if (!acc) timeout("send");
   endtask

   task automatic wait_cnt(input int c);
      int n = 0;
      while (!(wbit_valid_o && block_cnt_o == c) && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) timeout("wait_cnt");
   endtask

   task automatic drain();
      int n = 0;
      while (wbit_valid_o && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) timeout("drain");
   endtask

   initial begin
      int n, t0;
      rst_ni = 1'b0;
      enable_i = 1'b1; clear_i = 1'b0; qw_i = '0; row_mask_i = '0;
      wword_valid_i = 1'b0; wword_data_i = '0; wbit_ready_i = 1'b1;
      tick(); tick();
      chk("rst_valid", wbit_valid_o, 0);
      chk("rst_data", wbit_data_o, 0);
      chk("rst_cnt", block_cnt_o, 0);
      chk("rst_last", last_o, 0);
      chk("rst_ready", wword_ready_o, 1);
      rst_ni = 1'b1;
      tick();

      // Single 8-bit word, row0 = 0xA5
      send(72'hA5, 4'd8, 9'h1FF);
      n = 0;
      while (wbit_valid_o && n < 20) begin n++; tick(); end
      chk("a5_len", n, 8);

      // Back-to-back 3 words at qw=4, no bubble
      send({CS*QW/8{8'h3C}}, 4'd4, 9'h1FF);
      t0 = cyc;
      send({CS*QW/8{8'h96}}, 4'd4, 9'h1FF);
      send({CS*QW/8{8'h5A}}, 4'd4, 9'h1FF);
      drain();
      chk("b2b_cycles", cyc - t0, 12);

      // Backpressure at cnt=2
      send({$urandom, $urandom, $urandom}, 4'd8, 9'h1FF);
      wait_cnt(2);
      wbit_ready_i = 1'b0;
      repeat (5) tick();
      chk("stall_cnt", block_cnt_o, 2);
      chk("stall_valid", wbit_valid_o, 1);
      wbit_ready_i = 1'b1;
      drain();

      // Saturation and row mask
      send({$urandom, $urandom, $urandom}, 4'd0, 9'h0F0);
      send({$urandom, $urandom, $urandom}, 4'd12, 9'h0F0);
      drain();

      // Clear mid-word
      send({$urandom, $urandom, $urandom}, 4'd8, 9'h1FF);
      wait_cnt(5);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      chk("clr_valid", wbit_valid_o, 0);
      chk("clr_cnt", block_cnt_o, 0);
      send({$urandom, $urandom, $urandom}, 4'd8, 9'h1FF);
      drain();

      // Async reset mid-word
      send({$urandom, $urandom, $urandom}, 4'd8, 9'h1FF);
      wait_cnt(3);
      rst_ni = 1'b0;
      #1;
      chk("arst_valid", wbit_valid_o, 0);
      chk("arst_data", wbit_data_o, 0);
      chk("arst_cnt", block_cnt_o, 0);
      chk("arst_last", last_o, 0);
      tick();
      rst_ni = 1'b1;
      tick();

      // Enable freeze at cnt=1
      send({$urandom, $urandom, $urandom}, 4'd8, 9'h1FF);
      wait_cnt(1);
      enable_i = 1'b0;
      repeat (3) tick();
      chk("frz_cnt", block_cnt_o, 1);
      chk("frz_ready", wword_ready_o, 0);
      enable_i = 1'b1;
      drain();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         wword_valid_i = ($urandom_range(0, 1) == 1);
         wword_data_i  = {$urandom, $urandom, $urandom};
         qw_i          = 4'($urandom_range(0, 15));
         row_mask_i    = 9'($urandom);
         wbit_ready_i  = ($urandom_range(0, 3) != 0);
         enable_i      = ($urandom_range(0, 9) != 0);
         clear_i       = ($urandom_range(0, 39) == 0);
         tick();
      end
      wword_valid_i = 1'b0; enable_i = 1'b1; clear_i = 1'b0; wbit_ready_i = 1'b1;
      drain();
      tick();
      chk("sb_empty", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/neureka_weight_bitserializer.md
Name: neureka_weight_bitserializer

Overview:
Transmit side of the per-row 1-bit weight stream consumed by a neureka binconv column. Accepts one packed weight word per handshake: COLUMN_SIZE rows, each QW bits. Emits it as qw bit-planes, LSB first, one plane per accepted output beat. Also emits the bit index as block_cnt_o, which the column uses for scale shift selection, and a last-plane flag.

Parameters:
COLUMN_SIZE, 9, number of rows per column (one 1-bit weight per row per beat)
QW, 8, maximum weight precision in bits
CNT_W, $clog2(QW), width of the bit-index counter

Ports:
clk_gated  in  1  clock (already gated upstream)
rst_ni  in  1  reset, asynchronous, active-low
enable_i  in  1  local enable; low freezes all state and handshakes
clear_i  in  1  synchronous clear to IDLE
qw_i  in  CNT_W+1  active precision 1..QW; sampled at word load
row_mask_i  in  COLUMN_SIZE  per-row enable; masked rows drive 0
wword_valid_i  in  1  packed weight word valid
wword_ready_o  out  1  packed weight word ready
wword_data_i  in  COLUMN_SIZE*QW  row r occupies bits [r*QW +: QW]
wbit_valid_o  out  1  bit-plane valid (shared by all rows)
wbit_ready_i  in  1  bit-plane ready (shared; the column returns row 0 ready)
wbit_data_o  out  COLUMN_SIZE  bit-plane; bit r = weight bit block_cnt_o of row r
block_cnt_o  out  CNT_W  index of the bit currently presented
last_o  out  1  high when the current plane is the last plane of the word (block_cnt_o == qw_q-1)

Behaviour:
- Reset values: state=IDLE, word register 0, qw_q=1, cnt=0, mask register 0. Outputs: wbit_valid_o=0, wbit_data_o=0, block_cnt_o=0, last_o=0. wword_ready_o=enable_i & ~clear_i, combinationally.
- States: IDLE, SERIAL.
- Handshakes are evaluated only when enable_i=1 and clear_i=0. Otherwise wword_ready_o=0, wbit_valid_o keeps its registered value, and no state changes.
- IDLE: wword_ready_o=1.
  - On wword_valid_i: latch the word, row_mask_i and qw_i. qw_i=0 or qw_i>QW saturates to 1 or QW respectively. Set cnt=0 and go to SERIAL.
  - wbit_valid_o rises the cycle after acceptance (latency 1).
- SERIAL: wbit_valid_o=1; wbit_data_o[r] = word[r*QW+cnt] & mask[r]; block_cnt_o=cnt; last_o=(cnt==qw_q-1).
  - Output handshake with last_o=0: cnt increments.
  - Output handshake with last_o=1: wword_ready_o=1 combinationally in this same cycle.
    - If wword_valid_i=1, load the next word, cnt=0, and stay in SERIAL. There is no bubble: the back-to-back plane rate is 1 per cycle.
    - Otherwise go to IDLE; wbit_valid_o falls next cycle.
  - In SERIAL with last_o=0, wword_ready_o=0.
- Stall: while wbit_ready_i=0, wbit_data_o, block_cnt_o and last_o hold stable; valid must not drop.
- qw_q=1: every word produces exactly one plane with last_o=1 (the 1x1 / single-bit case).
- clear_i has priority over every handshake. Next cycle: IDLE, cnt=0, valid=0, word dropped mid-serialization. It takes effect even when enable_i=0.
- Asynchronous reset mid-word: immediate return to reset values; a partial word is never resumed.
- Cycle accounting: N words at qw bits with an always-ready sink take N*qw cycles after the first-load cycle.
- Changes to row_mask_i and qw_i during SERIAL have no effect until the next load.

Test Plan:
- Single word, QW=8, qw_i=8, sink always ready: row0=0xA5, others 0 -> row0 bit sequence 1,0,1,0,0,1,0,1; block_cnt 0..7; last_o only at cnt=7; valid for exactly 8 cycles starting 1 cycle after load.
- Back-to-back words, qw_i=4, valid held: 3 words -> 12 consecutive valid cycles, no bubble; wword_ready_o pulses coincide with the cnt=3 handshakes.
- Backpressure: wbit_ready_i low at cnt=2 for 5 cycles -> data, block_cnt=2 and valid are stable for the whole stall; the sequence resumes at cnt=3.
- qw_i=0 and qw_i=12 -> serialized as 1 and 8 planes respectively; row_mask_i=9'h0F0 -> rows 0-3 and 8 are always 0.
- clear_i asserted at cnt=5 of an 8-bit word -> next cycle valid=0, block_cnt=0; the next word starts at cnt 0. Repeat with rst_ni low mid-word: all outputs 0 immediately.
- enable_i low for 3 cycles at cnt=1 -> state frozen, wword_ready_o=0, no cnt advance even with wbit_ready_i=1; resumes at cnt=1.
